// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch-path types
// Purpose: reset PC, NOP encoding, PC step and the {pc, ir} entry type
//          used by the fetch stage and its queue.
// Ports:   none (package).
package cpu_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: imem request/response, redirect, decode stream
// Purpose: bundles the instruction-memory, redirect and decode-side signals.
// Ports (master = fetch_unit):
//   imem_pc out, imem_ir in, redirect_valid in, redirect_pc in,
//   out_valid out, out_ready in, out_pc out, out_ir out.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] imem_pc;
  logic [XLEN-1:0] imem_ir;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_ir;

  modport master (
    output imem_pc,
    input  imem_ir,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_ir
  );

  modport slave (
    input  imem_pc,
    output imem_ir,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_ir
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry {pc, ir} FIFO between imem response and decode
// Purpose: buffers returned instructions; head is read straight from flops.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   push, push_entry    write one {pc, ir} entry
//   pop                 remove head entry
//   flush               discard all entries (wins over push/pop)
//   count               occupancy 0..2
//   head                head entry, {0, NOP} when empty
module fetch_queue
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: '0, ir: NOP_INSN};

  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  logic [1:0]   count_q, count_d;
  logic         push_eff;
  logic         pop_eff;

  // Guard against misuse even though the fetch credit logic never violates these.
  assign pop_eff  = pop & (count_q != 2'd0);
  assign push_eff = push & ((count_q != 2'd2) | pop_eff);

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push_eff, pop_eff})
        2'b10: begin
          if (count_q == 2'd0) entry0_d = push_entry;
          else                 entry1_d = push_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          entry0_d = entry1_q;
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever survives the pop.
          if (count_q == 2'd2) begin
            entry0_d = entry1_q;
            entry1_d = push_entry;
          end else begin
            entry0_d = push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= EMPTY_ENTRY;
      entry1_q <= EMPTY_ENTRY;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = (count_q != 2'd0) ? entry0_q : EMPTY_ENTRY;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with redirect flush and 2-deep buffering
// Purpose: drives the fetch PC, tracks the one-cycle imem read latency and
//          credits the 2-entry queue so decode stalls never drop a word.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   bus            fetch_unit_if.master (imem, redirect, decode stream)
//   fetch_fault    sticky misaligned-redirect flag (FETCH_MISALIGN_CHECK_EN only)
// Build option: FETCH_MISALIGN_CHECK_EN enables misaligned-redirect faulting;
//               otherwise redirect_pc[1:0] is forced to zero.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        bus
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                fetch_fault
`endif
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      q_count;
  fetch_entry_t    q_head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            push;
  logic            issue;
  logic [2:0]      credit;
  logic            fault_q;
  logic [XLEN-1:0] redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_d;

  assign redirect_target = bus.redirect_pc;

  always_comb begin
    fault_d = fault_q;
    // Any redirect re-decides the fault: misaligned sets it, aligned clears it.
    if (bus.redirect_valid) fault_d = (bus.redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign fetch_fault = fault_q;
`else
  assign redirect_target = bus.redirect_pc & ~32'h0000_0003;
  assign fault_q         = 1'b0;
`endif

  assign pop = bus.out_valid & bus.out_ready;

  // Words already owned (buffered + in flight) after this cycle's pop must
  // leave room for one more request; pop only happens with count >= 1.
  assign credit = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = !bus.redirect_valid && (credit < 3'd2) && !fault_q;

  // A redirect kills the response of the request issued last cycle.
  assign push       = inflight_q & !bus.redirect_valid;
  assign push_entry = '{pc: inflight_pc_q, ir: bus.imem_ir};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_target;
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .count      (q_count),
    .head       (q_head)
  );

  assign bus.imem_pc   = fetch_pc_q;
  assign bus.out_valid = (q_count != 2'd0);
  assign bus.out_pc    = q_head.pc;
  assign bus.out_ir    = q_head.ir;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fetch_unit_if bus ();

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fetch_fault;
`endif

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_fault (fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory whose word equals its address.
  always @(posedge clk) bus.imem_ir <= bus.imem_pc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n              = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_ir        = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_imem_pc", bus.imem_pc, 32'h0);
    check_eq("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("rst_out_pc", bus.out_pc, 32'h0);
    check_eq("rst_out_ir", bus.out_ir, 32'h0000_0013);

    // Cycle 0 after release.
    rst_n = 1'b1;
    check_eq("c0_imem_pc", bus.imem_pc, 32'h0);
    step();
    check_eq("c1_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("c1_imem_pc", bus.imem_pc, 32'h4);
    step();
    check_eq("c2_valid", {31'b0, bus.out_valid}, 32'd1);
    check_eq("c2_out_pc", bus.out_pc, 32'h0);
    check_eq("c2_out_ir", bus.out_ir, 32'h0);
    step();
    check_eq("c3_out_pc", bus.out_pc, 32'h4);
    step();
    check_eq("c4_out_pc", bus.out_pc, 32'h8);

    // Decode stalls from cycle 4 through 8.
    bus.out_ready = 1'b0;
    repeat (5) step();
    check_eq("stall_out_pc", bus.out_pc, 32'h8);
    check_eq("stall_imem_pc", bus.imem_pc, 32'h10);
    check_eq("stall_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("resume_out_pc", bus.out_pc, 32'hC + 32'(4 * i));
      check_eq("resume_out_ir", bus.out_ir, 32'hC + 32'(4 * i));
    end

    // Redirect mid-stream while popping 0x14.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("redir_r1_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("redir_r1_imem_pc", bus.imem_pc, 32'h100);
    step();
    check_eq("redir_r2_valid", {31'b0, bus.out_valid}, 32'd0);
    step();
    check_eq("redir_r3_out_pc", bus.out_pc, 32'h100);
    check_eq("redir_r3_valid", {31'b0, bus.out_valid}, 32'd1);
    step();
    check_eq("redir_r4_out_pc", bus.out_pc, 32'h104);

    // Fill to two entries, then pop and redirect to near the top of memory together.
    bus.out_ready = 1'b0;
    step();
    check_eq("full_head_pc", bus.out_pc, 32'h104);
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("pop_redir_r1_valid", {31'b0, bus.out_valid}, 32'd0);
    step();
    check_eq("pop_redir_r2_valid", {31'b0, bus.out_valid}, 32'd0);
    step();
    check_eq("wrap_pc0", bus.out_pc, 32'hFFFF_FFF8);
    step();
    check_eq("wrap_pc1", bus.out_pc, 32'hFFFF_FFFC);
    step();
    check_eq("wrap_pc2", bus.out_pc, 32'h0000_0000);
    check_eq("wrap_ir2", bus.out_ir, 32'h0000_0000);

    // Misaligned redirect.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0102;
    step();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("fault_set", {31'b0, fetch_fault}, 32'd1);
    check_eq("fault_valid0", {31'b0, bus.out_valid}, 32'd0);
    repeat (3) step();
    check_eq("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    check_eq("fault_valid1", {31'b0, bus.out_valid}, 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("fault_clear", {31'b0, fetch_fault}, 32'd0);
    step();
    step();
    check_eq("fault_restart_pc", bus.out_pc, 32'h200);
    check_eq("fault_restart_valid", {31'b0, bus.out_valid}, 32'd1);
`else
    check_eq("align_imem_pc", bus.imem_pc, 32'h100);
    step();
    step();
    check_eq("align_out_pc", bus.out_pc, 32'h100);
    check_eq("align_out_valid", {31'b0, bus.out_valid}, 32'd1);
`endif

    // Asynchronous reset mid-stream takes effect without a clock edge.
    step();
    rst_n = 1'b0;
    #1;
    check_eq("async_valid", {31'b0, bus.out_valid}, 32'd0);
    check_eq("async_out_pc", bus.out_pc, 32'h0);
    check_eq("async_out_ir", bus.out_ir, 32'h0000_0013);
    check_eq("async_imem_pc", bus.imem_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("async_fault", {31'b0, fetch_fault}, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    step();
    check_eq("rerst_out_pc", bus.out_pc, 32'h0);
    check_eq("rerst_valid", {31'b0, bus.out_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction memory and feeds decode. Generates the fetch address, tracks the one-cycle synchronous read latency of the memory, and buffers returned instructions in a 2-entry queue so decode back-pressure never drops an in-flight word. Handles control-flow redirects from execute by flushing everything in flight and restarting at the target.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_pc  out  32  fetch byte address to instruction memory (registered)
- imem_ir  in  32  memory read data; word for imem_pc of the previous cycle
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  32  redirect target byte address
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts this cycle
- out_pc  out  32  byte address of out_ir
- out_ir  out  32  instruction word
- fetch_fault  out  1  misaligned redirect seen (only with FETCH_MISALIGN_CHECK_EN)

## Operation
- State: fetch_pc (drives imem_pc), inflight flag + inflight_pc (request issued last cycle), 2-entry FIFO of {pc, ir}, count 0..2.
- pop = out_valid & out_ready. out_valid = (count != 0); out_pc/out_ir = FIFO head, registered, no combinational path from imem_ir.
- issue = !redirect_valid & (count + inflight - pop < 2) [& !fault]. On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps 32'hFFFF_FFFC -> 0). Otherwise inflight<=0, fetch_pc holds.
- Response: if inflight & !redirect_valid, push {inflight_pc, imem_ir} into FIFO. Credit rule guarantees no overflow; push and pop in same cycle keep count.
- Redirect (highest priority): fetch_pc<=redirect_pc, FIFO cleared, inflight cleared (response killed), no issue that cycle. A pop in the redirect cycle is still a valid transfer.
- Empty FIFO: out_pc=0, out_ir=32'h0000_0013 (NOP).
- Reset (async, any time, including mid-redirect): fetch_pc=RESET_PC, inflight=0, count=0, out_valid=0, out_pc=0, out_ir=NOP, fetch_fault=0. Memory data during reset ignored.

## Timing
- Cycle 0 after rst_n release: imem_pc=RESET_PC, issue. Cycle 1: push. Cycle 2: out_valid=1, out_pc=RESET_PC.
- Redirect asserted in cycle R: imem_pc=target in R+1, out_valid=1 with out_pc=target in R+3; out_valid=0 in R+1, R+2.
- Sustained throughput 1 instr/cycle with out_ready held high (count=1, inflight=1 steady).
- out_ready low: at most 2 words buffered, fetch_pc stalls; resume on out_ready with no bubble beyond the single re-issue cycle.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 sets sticky fetch_fault, flushes, and stops issuing; cleared only by reset or a later aligned redirect, which restarts fetch normally.
- Not defined: fetch_fault port absent; redirect_pc[1:0] forced to 0 on load, no fault state.

## Structure
- Shared package cpu_pkg: RESET_PC default, NOP_INSN=32'h0000_0013, PC_STEP=4, XLEN=32.
- One sub-module: fetch_queue (2-entry {pc, ir} FIFO with push/pop/flush/count); fetch_unit holds PC, inflight tracking and credit logic.

## Test plan
- Reset release, out_ready=1, memory returns word = address: out_pc sequence 0,4,8,12 from cycle 2 on, one per cycle, out_ir matches.
- out_ready low cycles 4-9: count saturates at 2, imem_pc frozen, no word lost or duplicated when out_ready rises.
- redirect_valid with redirect_pc=32'h0000_0100 mid-stream: no out_valid for 2 cycles, then out_pc=0x100, 0x104; stale words never appear.
- Redirect in same cycle as pop with count=2: popped word delivered once, remaining entry and in-flight word discarded.
- redirect_pc=32'hFFFF_FFF8: out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With FETCH_MISALIGN_CHECK_EN, redirect_pc=0x102: fetch_fault=1, out_valid stays 0; aligned redirect to 0x200 clears fault, out_pc=0x200 three cycles later. Async reset asserted mid-stream returns all outputs to reset values immediately.
